// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and types shared by the fetch stage, the instruction
// ROM and the hex-view top level.
//   FETCH_ADDR_W   - default ROM address / PC width
//   FETCH_DATA_W   - default ROM word / IR width
//   FETCH_RESET_PC - PC value loaded by reset
//   fetch_state_e  - fetch sequencer states
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W   = 8;
  localparam int unsigned FETCH_DATA_W   = 32;
  localparam int unsigned FETCH_RESET_PC = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/rom_wait_counter.sv
// rom_wait_counter: loadable down-counter that times out a fixed memory read
// latency. Load it on the cycle before the wait begins; o_expire is high on
// the final wait cycle.
//   i_clk    - clock
//   i_rst    - synchronous active-high reset
//   i_load   - preload with LATENCY-1 (takes priority over counting)
//   i_run    - high while waiting; enables decrement and qualifies o_expire
//   o_expire - final wait cycle strobe
module rom_wait_counter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_expire
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(LATENCY - 1);
    end else if (i_run && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_expire = i_run && (r_count == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage. Holds the PC, issues one ROM read per
// fetch, waits out the ROM latency, latches the word into IR, then advances
// or redirects the PC.
//   Clock, Reset             - clock, synchronous active-high reset
//   Enable                   - run switch; gates acceptance of new fetches
//   FetchReq                 - fetch request, sampled only when idle
//   BranchTake/BranchTarget  - redirect PC (immediate when idle, pending when busy)
//   RomAddress/RomClken      - registered ROM address and clock-enable
//   RomQ                     - ROM read data
//   IR, PC                   - instruction register, program counter
//   FetchDone                - one-cycle pulse after IR is written
//   Busy                     - high whenever a fetch is in flight
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W      = FETCH_ADDR_W,
  parameter int unsigned DATA_W      = FETCH_DATA_W,
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned RESET_PC    = FETCH_RESET_PC
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              FetchReq,
  input  logic              BranchTake,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic [ADDR_W-1:0] RomAddress,
  output logic              RomClken,
  input  logic [DATA_W-1:0] RomQ,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] PC,
  output logic              FetchDone,
  output logic              Busy
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  fetch_state_e      r_state;
  fetch_state_e      w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_rom_clken;
  logic              r_done;
  logic              r_busy;
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_tgt;

  logic              w_accept;
  logic              w_expire;
  logic              w_complete;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic [ADDR_W-1:0] w_next_pc;

  assign w_accept     = (r_state == IDLE) && FetchReq && Enable;
  assign w_fetch_addr = BranchTake ? BranchTarget : r_pc;
  assign w_complete   = (r_state == WAIT) && w_expire;

  // A branch arriving on the completion edge is newer than any pending one.
  assign w_next_pc = BranchTake   ? BranchTarget :
                     r_pend_valid ? r_pend_tgt   :
                                    r_rom_addr + ADDR_W'(1);

  rom_wait_counter #(
    .LATENCY (ROM_LATENCY)
  ) u_wait (
    .i_clk    (Clock),
    .i_rst    (Reset),
    .i_load   (r_state == ISSUE),
    .i_run    (r_state == WAIT),
    .o_expire (w_expire)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next_state = ISSUE;
      ISSUE:   w_next_state = WAIT;
      WAIT:    if (w_expire) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pc         <= RST_PC;
      r_ir         <= '0;
      r_rom_addr   <= RST_PC;
      r_rom_clken  <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_tgt   <= '0;
    end else begin
      r_done <= w_complete;
      r_busy <= (w_next_state != IDLE);
      if (r_state == IDLE) begin
        if (w_accept) begin
          r_pc         <= w_fetch_addr;
          r_rom_addr   <= w_fetch_addr;
          r_rom_clken  <= 1'b1;
          r_pend_valid <= 1'b0;
        end else if (BranchTake) begin
          r_pc <= BranchTarget;
        end
      end else begin
        if (BranchTake) begin
          r_pend_valid <= 1'b1;
          r_pend_tgt   <= BranchTarget;
        end
        if (w_complete) begin
          r_ir         <= RomQ;
          r_rom_clken  <= 1'b0;
          r_pend_valid <= 1'b0;
          r_pc         <= w_next_pc;
        end
      end
    end
  end

  assign RomAddress = r_rom_addr;
  assign RomClken   = r_rom_clken;
  assign IR         = r_ir;
  assign PC         = r_pc;
  assign FetchDone  = r_done;
  assign Busy       = r_busy;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: two instances (ROM latency 1 and 2) share
// stimulus; each has its own ROM model and a transaction-level reference
// model checked every cycle, plus directed latency/boundary checks.
module tb_instruction_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic        FetchReq = 1'b0;
  logic        BranchTake = 1'b0;
  logic [7:0]  BranchTarget = '0;

  logic [7:0]  ra1, ra2, pc1, pc2;
  logic        ce1, ce2, fd1, fd2, bz1, bz2;
  logic [31:0] q1, q2, ir1, ir2;
  logic [31:0] q2_stage;
  logic [31:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  instruction_fetch_unit #(.ADDR_W(8), .DATA_W(32), .ROM_LATENCY(1), .RESET_PC(0)) dut1 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .FetchReq(FetchReq),
    .BranchTake(BranchTake), .BranchTarget(BranchTarget),
    .RomAddress(ra1), .RomClken(ce1), .RomQ(q1),
    .IR(ir1), .PC(pc1), .FetchDone(fd1), .Busy(bz1));

  instruction_fetch_unit #(.ADDR_W(8), .DATA_W(32), .ROM_LATENCY(2), .RESET_PC(0)) dut2 (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .FetchReq(FetchReq),
    .BranchTake(BranchTake), .BranchTarget(BranchTarget),
    .RomAddress(ra2), .RomClken(ce2), .RomQ(q2),
    .IR(ir2), .PC(pc2), .FetchDone(fd2), .Busy(bz2));

  // ROM models: address captured on a clken edge, q valid LATENCY edges later
  always @(posedge Clock) if (ce1) q1 <= mem[ra1];
  always @(posedge Clock) if (ce2) begin q2_stage <= mem[ra2]; q2 <= q2_stage; end

  typedef struct {
    bit          busy;
    int          left;   // edges until the fetch completes
    logic [7:0]  pc;
    logic [7:0]  addr;
    logic [31:0] ir;
    bit          clken;
    bit          done;
    bit          pv;
    logic [7:0]  pt;
  } mdl_t;

  mdl_t m1, m2;

  function automatic mdl_t mstep(mdl_t s, int lat);
    mdl_t n = s;
    n.done = 0;
    if (Reset) begin
      n.busy = 0; n.left = 0; n.pc = 0; n.addr = 0; n.ir = 0;
      n.clken = 0; n.pv = 0; n.pt = 0;
    end else if (!s.busy) begin
      if (FetchReq && Enable) begin
        n.pc    = BranchTake ? BranchTarget : s.pc;
        n.addr  = n.pc;
        n.clken = 1;
        n.busy  = 1;
        n.left  = lat + 1;
        n.pv    = 0;
      end else if (BranchTake) begin
        n.pc = BranchTarget;
      end
    end else begin
      n.left = s.left - 1;
      if (BranchTake) begin n.pv = 1; n.pt = BranchTarget; end
      if (s.left == 1) begin
        n.ir    = mem[s.addr];
        n.done  = 1;
        n.busy  = 0;
        n.clken = 0;
        n.pc    = BranchTake ? BranchTarget : (s.pv ? s.pt : 8'(s.addr + 1));
        n.pv    = 0;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cmp(input string who, input mdl_t m, input logic [7:0] ra, input logic ce,
                     input logic [31:0] ir, input logic [7:0] pc, input logic fd, input logic bz);
    check({who, ".RomAddress"}, 64'(ra), 64'(m.addr));
    check({who, ".RomClken"},   64'(ce), 64'(m.clken));
    check({who, ".IR"},         64'(ir), 64'(m.ir));
    check({who, ".PC"},         64'(pc), 64'(m.pc));
    check({who, ".FetchDone"},  64'(fd), 64'(m.done));
    check({who, ".Busy"},       64'(bz), 64'(m.busy));
  endtask

  task automatic tick();
    @(posedge Clock);
    m1 = mstep(m1, 1);
    m2 = mstep(m2, 2);
    @(negedge Clock);
    cmp("d1", m1, ra1, ce1, ir1, pc1, fd1, bz1);
    cmp("d2", m2, ra2, ce2, ir2, pc2, fd2, bz2);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bz1 || bz2) && n < 20) begin tick(); n++; end
    check("drain_timeout", 64'({bz1, bz2}), 64'(0));
  endtask

  task automatic do_reset(input int cycles);
    Reset = 1'b1;
    repeat (cycles) tick();
    Reset = 1'b0;
  endtask

  initial begin
    int lat1, lat2, pulses;
    logic [7:0] pc_hold;

    foreach (mem[i]) mem[i] = $urandom;
    mem[0] = 32'h1234_ABCD;

    // Reset state
    do_reset(2);
    check("rst.PC", 64'(pc1), 64'(0));
    check("rst.IR", 64'(ir1), 64'(0));

    // Single fetch with latency measurement on both instances
    Enable = 1'b1;
    FetchReq = 1'b1;
    lat1 = 0; lat2 = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      FetchReq = 1'b0;
      if (k == 1) begin
        check("issue.RomAddress", 64'(ra1), 64'(0));
        check("issue.RomClken", 64'(ce1), 64'(1));
      end
      if (fd1 && lat1 == 0) lat1 = k;
      if (fd2 && lat2 == 0) lat2 = k;
    end
    check("latency_L1", 64'(lat1), 64'(3));
    check("latency_L2", 64'(lat2), 64'(4));
    check("single.IR", 64'(ir1), 64'(32'h1234_ABCD));
    check("single.PC", 64'(pc1), 64'(1));

    // Back-to-back from PC 0
    do_reset(2);
    FetchReq = 1'b1;
    pulses = 0;
    repeat (9) begin tick(); if (fd1) pulses++; end
    FetchReq = 1'b0;
    check("b2b.pulses", 64'(pulses), 64'(3));
    check("b2b.PC", 64'(pc1), 64'(3));
    check("b2b.IR", 64'(ir1), 64'(mem[2]));
    wait_idle();

    // PC wrap
    BranchTake = 1'b1; BranchTarget = 8'hFF;
    tick();
    BranchTake = 1'b0;
    FetchReq = 1'b1;
    tick();
    FetchReq = 1'b0;
    wait_idle();
    check("wrap.IR", 64'(ir1), 64'(mem[255]));
    check("wrap.PC", 64'(pc1), 64'(0));

    // Branch together with request
    BranchTake = 1'b1; BranchTarget = 8'h40; FetchReq = 1'b1;
    tick();
    BranchTake = 1'b0; FetchReq = 1'b0;
    wait_idle();
    check("brreq.IR", 64'(ir1), 64'(mem[8'h40]));
    check("brreq.PC", 64'(pc1), 64'(8'h41));

    // Branch while busy
    FetchReq = 1'b1;
    tick();
    FetchReq = 1'b0;
    BranchTake = 1'b1; BranchTarget = 8'h10;
    tick();
    BranchTake = 1'b0;
    wait_idle();
    check("brbusy.IR", 64'(ir1), 64'(mem[8'h41]));
    check("brbusy.PC", 64'(pc1), 64'(8'h10));

    // Reset mid-fetch
    FetchReq = 1'b1;
    tick();
    FetchReq = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midrst.Busy", 64'(bz1), 64'(0));
    check("midrst.RomClken", 64'(ce1), 64'(0));
    check("midrst.IR", 64'(ir1), 64'(0));
    check("midrst.PC", 64'(pc1), 64'(0));
    pulses = 0;
    repeat (6) begin tick(); if (fd1 || fd2) pulses++; end
    check("midrst.nodone", 64'(pulses), 64'(0));

    // Enable low blocks new fetches
    pc_hold = pc1;
    Enable = 1'b0; FetchReq = 1'b1;
    repeat (5) begin tick(); check("en0.RomClken", 64'(ce1 | ce2), 64'(0)); end
    FetchReq = 1'b0; Enable = 1'b1;
    check("en0.PC", 64'(pc1), 64'(pc_hold));

    // Randomized traffic against the reference model
    repeat (400) begin
      FetchReq     = 1'($urandom_range(0, 1));
      Enable       = ($urandom_range(0, 3) != 0);
      BranchTake   = ($urandom_range(0, 4) == 0);
      BranchTarget = 8'($urandom);
      Reset        = ($urandom_range(0, 59) == 0);
      tick();
    end
    Reset = 1'b0; FetchReq = 1'b0; BranchTake = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
